// File: rtl/alarm_button_pio_if.sv
// Avalon-MM slave bus bundle for the alarm-clock button input port.
// The master modport belongs to the bus side (CPU or bench); the slave modport belongs to the PIO.
interface alarm_button_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/alarm_button_pio.sv
// alarm_button_pio: Avalon-MM input PIO for the alarm-clock keys.
// The pins pass through a 2-FF synchronizer and then an optional per-bit debouncer.
// Edges are latched into a sticky W1C capture register, and a level IRQ is raised for masked bits.
// Build option: define BUTTON_PIO_DEBOUNCE_EN to enable the stable-count debouncer.
// Without it, the debounced state simply follows the synchronizer one cycle later.
module alarm_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 0,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  alarm_button_pio_if.slave    bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0] sync1, sync2, deb, prev, mask, edge_cap;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic             bus_wr;

  assign bus_wr = bus.chipselect & ~bus.write_n;

  // Two-flop synchronizer; reset to the released level so that reset cannot fake a key press
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= {WIDTH{IDLE_LEVEL}};
      sync2 <= {WIDTH{IDLE_LEVEL}};
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0][CW-1:0] cnt;

  // Per-bit debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive mismatching
  // samples. Any sample that matches again restarts the count, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      deb <= {WIDTH{IDLE_LEVEL}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  // No debounce: follow the synchronizer (3-cycle pin-to-DATA latency)
  always_ff @(posedge clk) begin
    if (reset) deb <= {WIDTH{IDLE_LEVEL}};
    else       deb <= sync2;
  end
`endif

  // Previous-cycle debounced state, used for edge detection
  always_ff @(posedge clk) begin
    if (reset) prev <= {WIDTH{IDLE_LEVEL}};
    else       prev <= deb;
  end

  // Edge selection: 0 = falling edge (key press on active-low keys), 1 = rising edge, other = any edge
  always_comb begin
    edge_set = prev ^ deb;
    if (EDGE_TYPE == 0)      edge_set = prev & ~deb;
    else if (EDGE_TYPE == 1) edge_set = ~prev & deb;
  end

  assign edge_clr = (bus_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Sticky capture with W1C; a new edge overrides a clear of the same bit in the same cycle
  always_ff @(posedge clk) begin
    if (reset) edge_cap <= '0;
    else       edge_cap <= (edge_cap & ~edge_clr) | edge_set;
  end

  // Interrupt mask register
  always_ff @(posedge clk) begin
    if (reset)                             mask <= '0;
    else if (bus_wr && bus.address == 2'd2) mask <= bus.writedata[WIDTH-1:0];
  end

  // Zero-wait-state read mux; address 1 and the upper bits read as zero
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[WIDTH-1:0] = deb;
      2'd2:    bus.readdata[WIDTH-1:0] = mask;
      2'd3:    bus.readdata[WIDTH-1:0] = edge_cap;
      default: bus.readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & mask);

  // Upper writedata bits are unused by design; DEBOUNCE_CYCLES is unused without the debouncer
  logic unused_bits;
  assign unused_bits = ^{bus.writedata, DEBOUNCE_CYCLES[0]};

endmodule
